// File: rtl/smpl_trig_gen_if.sv
// Control/status bundle of the sample-rate trigger generator.
// Optional overrun counter: SMPL_TRIG_OVR_CNT_EN (see smpl_trig_gen.sv).
interface smpl_trig_gen_if #(
    parameter int NCH   = 2,
    parameter int DIV_W = 12
);
    // Handshake: trig[k] is a one-cycle request to channel k, which answers with a
    // one-cycle done[k]; busy[k] spans trig..done and a trig while busy flags ovr[k].
    logic             en;
    logic [DIV_W-1:0] div_val;
    logic             div_load;
    logic [NCH-1:0]   done;
    logic             ovr_clr;
    logic [NCH-1:0]   trig;
    logic [NCH-1:0]   busy;
    logic [NCH-1:0]   ovr;
    logic [7:0]       ovr_cnt;
    logic [DIV_W-1:0] dbg_cnt;
    logic [DIV_W-1:0] dbg_div_r;
    logic             dbg_pend;

    modport master (
        output en, div_val, div_load, done, ovr_clr,
        input  trig, busy, ovr, ovr_cnt, dbg_cnt, dbg_div_r, dbg_pend
    );

    modport slave (
        input  en, div_val, div_load, done, ovr_clr,
        output trig, busy, ovr, ovr_cnt, dbg_cnt, dbg_div_r, dbg_pend
    );
endinterface

// File: rtl/smpl_trig_gen.sv
// Multi-channel sample-rate trigger generator with shadowed frame divider and overrun tracking.
// Define SMPL_TRIG_OVR_CNT_EN to build the saturating total overrun counter.
module smpl_trig_gen #(
    parameter int NCH         = 2,
    parameter int DIV_W       = 12,
    parameter int DEFAULT_DIV = 2083,
    parameter int STAGGER     = 0
) (
    input logic             clk,
    input logic             reset,
    smpl_trig_gen_if.slave  bus
);
    localparam int               MIN_DIV   = (NCH - 1) * STAGGER + 2;
    localparam logic [DIV_W-1:0] MIN_DIV_V = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0] DEF_DIV_V = DIV_W'(DEFAULT_DIV);

    if (DEFAULT_DIV < MIN_DIV) begin : g_bad_default_div
        $error("smpl_trig_gen: DEFAULT_DIV below (NCH-1)*STAGGER+2");
    end

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] shadow;
    logic             pend;
    logic [NCH-1:0]   trig_r;
    logic [NCH-1:0]   busy_r;
    logic [NCH-1:0]   ovr_r;

    logic             wrap;
    logic [DIV_W-1:0] div_clamped;
    logic [NCH-1:0]   fire;
    logic [NCH-1:0]   ovr_evt;
    logic [NCH-1:0]   busy_nxt;
    logic [NCH-1:0]   ovr_nxt;

    assign wrap        = (cnt == div_r - DIV_W'(1));
    assign div_clamped = (bus.div_val < MIN_DIV_V) ? MIN_DIV_V : bus.div_val;

    // fire is the value trig takes on this edge; busy/ovr react to it, not to trig_r.
    always_comb begin
        fire = '0;
        for (int k = 0; k < NCH; k++) begin
            fire[k] = bus.en && (cnt == DIV_W'(k * STAGGER));
        end
        ovr_evt  = fire & busy_r & ~bus.done;
        busy_nxt = fire | (busy_r & ~bus.done);
        ovr_nxt  = ovr_evt | (ovr_r & ~{NCH{bus.ovr_clr}});
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt    <= '0;
            div_r  <= DEF_DIV_V;
            shadow <= '0;
            pend   <= 1'b0;
            trig_r <= '0;
            busy_r <= '0;
            ovr_r  <= '0;
        end else begin
            trig_r <= fire;
            busy_r <= busy_nxt;
            ovr_r  <= ovr_nxt;
            if (!bus.en) begin
                cnt <= '0;
            end else if (wrap) begin
                cnt <= '0;
                if (pend) begin
                    div_r <= shadow;
                    pend  <= 1'b0;
                end
            end else begin
                cnt <= cnt + DIV_W'(1);
            end
            // A load coinciding with the boundary re-arms pend for the following frame.
            if (bus.div_load) begin
                shadow <= div_clamped;
                pend   <= 1'b1;
            end
        end
    end

`ifdef SMPL_TRIG_OVR_CNT_EN
    logic [7:0] ovr_cnt_r;
    logic [4:0] n_evt;
    logic [8:0] cnt_sum;

    always_comb begin
        n_evt = '0;
        for (int k = 0; k < NCH; k++) begin
            n_evt = n_evt + 5'(ovr_evt[k]);
        end
        cnt_sum = (bus.ovr_clr ? 9'd0 : {1'b0, ovr_cnt_r}) + 9'(n_evt);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ovr_cnt_r <= '0;
        end else begin
            ovr_cnt_r <= cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
        end
    end

    assign bus.ovr_cnt = ovr_cnt_r;
`else
    assign bus.ovr_cnt = 8'd0;
`endif

    assign bus.trig      = trig_r;
    assign bus.busy      = busy_r;
    assign bus.ovr       = ovr_r;
    assign bus.dbg_cnt   = cnt;
    assign bus.dbg_div_r = div_r;
    assign bus.dbg_pend  = pend;
endmodule
